change_dispenser: RTL
=====================

# change_dispenser

Coin-return block for the vending machine: the output side of the nickel/dime coin path. On a `start` request it computes change as credit minus price, in nickel units. It checks the change against its internal dime and nickel inventory, then dispenses coins one at a time, dimes first, through a ready/acknowledge handshake with the ejector mechanism. Infeasible requests are rejected with an error pulse and no coins are dispensed.

## Interface
Parameters:
- `W`, 8, width of credit/price/change in nickel units (1 unit = 5 cents)
- `INV_W`, 8, width of inventory counters
- `DIME_INIT`, 20, dime inventory after reset or refill
- `NICKEL_INIT`, 20, nickel inventory after reset or refill

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `credit`  in  W  inserted amount, nickel units; sampled with `start`
- `price`  in  W  item price, nickel units; sampled with `start`
- `coin_ack`  in  1  ejector has released the currently requested coin
- `refill`  in  1  restore both inventories to INIT values; honoured only in IDLE
- `busy`  out  1  high in every state except IDLE
- `dime_out`  out  1  request one dime (level, high throughout DISP_D)
- `nickel_out`  out  1  request one nickel (level, high throughout DISP_N)
- `done`  out  1  1-cycle pulse, change fully dispensed
- `error`  out  1  1-cycle pulse, request rejected
- `dimes_left`  out  INV_W  current dime inventory
- `nickels_left`  out  INV_W  current nickel inventory

## Operation
- States: IDLE, CALC, DISP_D, DISP_N, DONE, ERR. All control outputs are decoded from the registered state (Moore).
- IDLE, `start`=1:
  - latch `credit` and `price`; go to CALC.
  - `start` and `refill` in the same cycle: start wins, refill is ignored.
- IDLE, `refill`=1 and `start`=0: `dimes_left`←DIME_INIT, `nickels_left`←NICKEL_INIT; stay in IDLE.
- CALC (exactly 1 cycle):
  - credit < price → ERR.
  - Otherwise compute:
    - chg = credit − price (W bits)
    - nd = min(chg>>1, dimes_left)
    - nn = chg − 2·nd (zero-extend to compare with INV_W values)
  - nn > nickels_left → ERR.
  - chg = 0 → DONE.
  - Otherwise load the remaining-dime count with nd and the remaining-nickel count with nn; go to DISP_D if nd > 0, else DISP_N.
- DISP_D, each cycle with `coin_ack`=1:
  - remaining dimes −1, `dimes_left` −1.
  - On the last dime, go to DISP_N if nn > 0, else DONE.
  - Back-to-back acks are legal, one coin per ack.
- DISP_N: same rules with nickels; the last nickel goes to DONE.
- DONE → IDLE with `done`=1 for that cycle. ERR → IDLE with `error`=1 for that cycle. Inventory is never modified on the error path.
- `coin_ack` outside DISP_D/DISP_N is ignored. `start` and `refill` while `busy` are ignored, with no queuing.
- Inventory counters never underflow: CALC guarantees sufficiency.
- Reset, at any time including mid-dispense:
  - state IDLE; `busy`, `dime_out`, `nickel_out`, `done`, `error` = 0.
  - `dimes_left`=DIME_INIT, `nickels_left`=NICKEL_INIT.
  - Remaining counts cleared; a partially dispensed request is abandoned.

## Timing
- `start` sampled at edge 0; CALC during cycle 1.
- First `dime_out`/`nickel_out` high in cycle 2. With zero change, `done` in cycle 2. Error cases give `error` in cycle 2.
- Ack in cycle k while in a DISP state:
  - the inventory output reflects the decrement in cycle k+1.
  - the next state is entered at k+1.
- `done` is asserted the cycle after the final ack.
- `busy` drops in the cycle after DONE/ERR. A new `start` is accepted in that IDLE cycle.
- Best case (all acks tied high): N coins complete with `done` in cycle 2+N.

## Test plan
- Reset: assert `reset` 2 cycles → all 1-bit outputs 0, `dimes_left`=20, `nickels_left`=20, `busy`=0.
- Single dime, `coin_ack` tied 1: credit=5, price=3 → `dime_out` in cycle 2 only, `done` in cycle 3, `dimes_left`=19, `nickels_left`=20.
- Mixed change, each ack delayed 3 cycles: credit=7, price=2 (chg 5) → two dimes then one nickel, `dime_out` held until each ack, `done` after the third ack, inventories 18/19.
- Dime shortage: DIME_INIT=1, credit=4, price=0 → 1 dime then 2 nickels, `done`, inventories 0/18.
- Rejects: credit=2, price=3 → `error` in cycle 2, no coin outputs, inventories unchanged. Then NICKEL_INIT=0, credit=1, price=0 → `error`, inventories unchanged.
- Interference:
  - `start` while busy is ignored.
  - `start`+`refill` together: start accepted, no refill.
  - `reset` asserted mid-DISP_D: next cycle IDLE, all control outputs 0, inventories back to INIT.

Source files
------------

// File: rtl/change_dispenser_if.sv
// change_dispenser_if
//   Request/handshake bundle between the vending controller (master) and the
//   coin-return block (slave).
//   master -> slave : start, credit, price (nickel units), coin_ack, refill
//   slave -> master : busy, dime_out, nickel_out, done, error,
//                     dimes_left, nickels_left
interface change_dispenser_if #(
  parameter int W     = 8,
  parameter int INV_W = 8
) ();
  logic             start;
  logic [W-1:0]     credit;
  logic [W-1:0]     price;
  logic             coin_ack;
  logic             refill;
  logic             busy;
  logic             dime_out;
  logic             nickel_out;
  logic             done;
  logic             error;
  logic [INV_W-1:0] dimes_left;
  logic [INV_W-1:0] nickels_left;

  modport master (
    output start, credit, price, coin_ack, refill,
    input  busy, dime_out, nickel_out, done, error, dimes_left, nickels_left
  );

  modport slave (
    input  start, credit, price, coin_ack, refill,
    output busy, dime_out, nickel_out, done, error, dimes_left, nickels_left
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser
//   Coin-return block. On start, computes change = credit - price (nickel
//   units), checks it against the dime/nickel inventory, then releases coins
//   one per coin_ack, dimes first. Infeasible requests give a one-cycle
//   error pulse and leave the inventory untouched.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high; returns to IDLE and restores inventory
//   bus    - change_dispenser_if.slave: start/credit/price/coin_ack/refill in,
//            busy/dime_out/nickel_out/done/error/dimes_left/nickels_left out
module change_dispenser #(
  parameter int W           = 8,
  parameter int INV_W       = 8,
  parameter int DIME_INIT   = 20,
  parameter int NICKEL_INIT = 20
) (
  input  logic                clk,
  input  logic                reset,
  change_dispenser_if.slave   bus
);

  // Common width so change and inventory values compare without truncation.
  localparam int CW = (W > INV_W) ? W : INV_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_DISP_D, S_DISP_N, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     credit_q, credit_d;
  logic [W-1:0]     price_q, price_d;
  logic [INV_W-1:0] rem_d_q, rem_d_d;
  logic [INV_W-1:0] rem_n_q, rem_n_d;
  logic [INV_W-1:0] dimes_q, dimes_d;
  logic [INV_W-1:0] nickels_q, nickels_d;

  logic [W-1:0]     chg;
  logic [CW-1:0]    chg_w;
  logic [CW-1:0]    nd_w;
  logic [CW-1:0]    nn_w;

  function automatic logic [CW-1:0] min_cw(input logic [CW-1:0] a,
                                           input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Change split: as many dimes as the inventory allows, remainder in nickels.
  // nd <= chg/2, so 2*nd never exceeds chg and nn cannot wrap.
  always_comb begin
    chg   = credit_q - price_q;
    chg_w = CW'(chg);
    nd_w  = min_cw(chg_w >> 1, CW'(dimes_q));
    nn_w  = chg_w - (nd_w << 1);
  end

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    price_d   = price_q;
    rem_d_d   = rem_d_q;
    rem_n_d   = rem_n_q;
    dimes_d   = dimes_q;
    nickels_d = nickels_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          credit_d = bus.credit;
          price_d  = bus.price;
          state_d  = S_CALC;
        end else if (bus.refill) begin
          dimes_d   = INV_W'(DIME_INIT);
          nickels_d = INV_W'(NICKEL_INIT);
        end
      end
      S_CALC: begin
        if (credit_q < price_q) begin
          state_d = S_ERR;
        end else if (nn_w > CW'(nickels_q)) begin
          state_d = S_ERR;
        end else if (chg == '0) begin
          state_d = S_DONE;
        end else begin
          // Both counts fit INV_W: nd <= dimes_left and nn <= nickels_left.
          rem_d_d = nd_w[INV_W-1:0];
          rem_n_d = nn_w[INV_W-1:0];
          state_d = (nd_w != '0) ? S_DISP_D : S_DISP_N;
        end
      end
      S_DISP_D: begin
        if (bus.coin_ack) begin
          rem_d_d = rem_d_q - INV_W'(1);
          dimes_d = dimes_q - INV_W'(1);
          if (rem_d_q == INV_W'(1)) begin
            state_d = (rem_n_q != '0) ? S_DISP_N : S_DONE;
          end
        end
      end
      S_DISP_N: begin
        if (bus.coin_ack) begin
          rem_n_d   = rem_n_q - INV_W'(1);
          nickels_d = nickels_q - INV_W'(1);
          if (rem_n_q == INV_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rem_d_q   <= '0;
      rem_n_q   <= '0;
      dimes_q   <= INV_W'(DIME_INIT);
      nickels_q <= INV_W'(NICKEL_INIT);
    end else begin
      state_q   <= state_d;
      rem_d_q   <= rem_d_d;
      rem_n_q   <= rem_n_d;
      dimes_q   <= dimes_d;
      nickels_q <= nickels_d;
    end
  end

  // Request operands are only meaningful after a start, so no reset needed.
  always_ff @(posedge clk) begin
    credit_q <= credit_d;
    price_q  <= price_d;
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.dime_out     = (state_q == S_DISP_D);
  assign bus.nickel_out   = (state_q == S_DISP_N);
  assign bus.done         = (state_q == S_DONE);
  assign bus.error        = (state_q == S_ERR);
  assign bus.dimes_left   = dimes_q;
  assign bus.nickels_left = nickels_q;

endmodule
